// File: rtl/cb_credit_tx_if.sv
// rtl/cb_credit_tx_if.sv - producer, FIFO-write and credit-return signals of the credit transmit stage
interface cb_credit_tx_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 4
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              cr_valid;
    logic [CNT_W-1:0]  cr_count;

    // transmit stage side
    modport master (
        input  s_valid, s_data, cr_valid, cr_count,
        output s_ready, tx_valid, tx_data
    );

    // producer / FIFO / credit-return side
    modport slave (
        output s_valid, s_data, cr_valid, cr_count,
        input  s_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/cb_credit_tx.sv
// rtl/cb_credit_tx.sv - two-entry buffered, credit-gated write stage feeding a credit-based FIFO
module cb_credit_tx #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    cb_credit_tx_if.master   bus,
    output logic [CNT_W-1:0] credits,
    output logic [CNT_W-1:0] in_flight,
    output logic             idle,
    output logic             err_overflow
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_X = (CNT_W + 1)'(DEPTH);

    // head is the oldest buffered word, tail the second one when occ == 2
    logic [1:0]        occ;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tail;
    logic              push;
    logic              launch;
    logic [CNT_W:0]    sum;

    // ready depends only on registered occupancy and reset, never on s_valid
    assign bus.s_ready = (occ < 2'd2) && !rst;
    assign push        = bus.s_valid && bus.s_ready;
    assign launch      = (occ != 2'd0) && (credits != '0);
    assign in_flight   = DEPTH_C - credits;
    assign idle        = (occ == 2'd0) && (credits == DEPTH_C) && !bus.tx_valid;

    // credit arithmetic one bit wider so an oversized return is detectable
    always_comb begin
        sum = {1'b0, credits} - {{CNT_W{1'b0}}, launch};
        if (bus.cr_valid) begin
            sum = sum + {1'b0, bus.cr_count};
        end
    end

    // input buffer: shift tail into head on pop, append the pushed word behind
    always_ff @(posedge clk) begin
        if (rst) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            if (launch) begin
                if (occ == 2'd2) begin
                    head <= tail;
                end else if (push) begin
                    head <= bus.s_data;
                end
            end else if (push) begin
                if (occ == 2'd0) begin
                    head <= bus.s_data;
                end else begin
                    tail <= bus.s_data;
                end
            end
            case ({push, launch})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // write strobe toward the FIFO; data holds between launches
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.tx_valid <= 1'b0;
            bus.tx_data  <= '0;
        end else begin
            bus.tx_valid <= launch;
            if (launch) begin
                bus.tx_data <= head;
            end
        end
    end

    // credit counter with saturation at DEPTH and a sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            credits      <= DEPTH_C;
            err_overflow <= 1'b0;
        end else if (sum > DEPTH_X) begin
            credits      <= DEPTH_C;
            err_overflow <= 1'b1;
        end else begin
            credits <= sum[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_cb_credit_tx.sv
// tb/tb_cb_credit_tx.sv - directed and soak bench for cb_credit_tx
module tb_cb_credit_tx;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    logic clk;
    logic rst;
    logic [CNT_W-1:0] credits;
    logic [CNT_W-1:0] in_flight;
    logic idle;
    logic err_overflow;

    int total;
    int bad;

    cb_credit_tx_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    cb_credit_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.master),
        .credits      (credits),
        .in_flight    (in_flight),
        .idle         (idle),
        .err_overflow (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] wd;
    int idx;
    int nl;
    int ret_pending;
    int inv;
    bit pre_sr;
    bit pre_tv;
    bit pop;
    logic [31:0] pre_td;
    logic [31:0] sdat;

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.cr_valid = 1'b0;
        bus.cr_count = '0;

        // reset and idle
        step();
        chk("rst_s_ready", bus.s_ready, 0);
        step();
        rst = 1'b0;
        #1;
        chk("rst_credits", credits, 8);
        chk("rst_in_flight", in_flight, 0);
        chk("rst_idle", idle, 1);
        chk("rst_s_ready_rel", bus.s_ready, 1);
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_err", err_overflow, 0);

        // single word: push at edge N, launch at edge N+1
        bus.s_valid = 1'b1;
        bus.s_data = 32'hA5A5_0001;
        step();
        bus.s_valid = 1'b0;
        chk("single_no_tx_yet", bus.tx_valid, 0);
        step();
        chk("single_tx_valid", bus.tx_valid, 1);
        chk("single_tx_data", bus.tx_data, 32'hA5A5_0001);
        chk("single_credits", credits, 7);
        chk("single_in_flight", in_flight, 1);
        chk("single_idle", idle, 0);
        step();
        chk("single_tx_drop", bus.tx_valid, 0);
        chk("single_data_hold", bus.tx_data, 32'hA5A5_0001);
        bus.cr_valid = 1'b1;
        bus.cr_count = 4'd1;
        step();
        bus.cr_valid = 1'b0;
        chk("single_ret_credits", credits, 8);
        chk("single_ret_idle", idle, 1);

        // exhaustion: ten words, eight credits
        idx = 0;
        nl = 0;
        for (int c = 0; c < 20; c++) begin
            bus.s_valid = (idx < 10);
            bus.s_data = 32'hA5A5_0000 + 32'(idx);
            pre_sr = bus.s_ready;
            step();
            if (bus.s_valid && pre_sr) idx++;
            if (bus.tx_valid) begin
                chk("exh_order", bus.tx_data, 32'hA5A5_0000 + 32'(nl));
                nl++;
            end
        end
        bus.s_valid = 1'b0;
        chk("exh_launches", nl, 8);
        chk("exh_accepted", idx, 10);
        chk("exh_credits", credits, 0);
        chk("exh_in_flight", in_flight, 8);
        chk("exh_s_ready", bus.s_ready, 0);
        chk("exh_tx_valid", bus.tx_valid, 0);

        // zero-count return changes nothing
        bus.cr_valid = 1'b1;
        bus.cr_count = 4'd0;
        step();
        chk("zero_ret_credits", credits, 0);
        chk("zero_ret_tx", bus.tx_valid, 0);

        // one credit back at edge M, launch at M+1
        bus.cr_count = 4'd1;
        step();
        bus.cr_valid = 1'b0;
        chk("ret1_credits", credits, 1);
        chk("ret1_no_same_edge", bus.tx_valid, 0);
        step();
        chk("ret1_tx_valid", bus.tx_valid, 1);
        chk("ret1_tx_data", bus.tx_data, 32'hA5A5_0008);
        chk("ret1_credits_after", credits, 0);
        step();
        chk("ret1_tx_drop", bus.tx_valid, 0);
        chk("ret1_s_ready", bus.s_ready, 1);

        // return exactly DEPTH: no overflow, then drain last word
        bus.cr_valid = 1'b1;
        bus.cr_count = 4'd8;
        step();
        bus.cr_valid = 1'b0;
        chk("full_ret_credits", credits, 8);
        chk("full_ret_err", err_overflow, 0);
        step();
        chk("drain_tx_valid", bus.tx_valid, 1);
        chk("drain_tx_data", bus.tx_data, 32'hA5A5_0009);
        chk("drain_credits", credits, 7);
        bus.cr_valid = 1'b1;
        bus.cr_count = 4'd1;
        step();
        bus.cr_valid = 1'b0;
        chk("drain_idle", idle, 1);
        chk("drain_credits_back", credits, 8);

        // simultaneous push, launch and return at credits = 4
        for (int c = 0; c < 16; c++) begin
            bus.s_valid = 1'b1;
            bus.s_data = 32'hC000_0000 + 32'(c);
            bus.cr_valid = (c >= 5);
            bus.cr_count = 4'd1;
            step();
            chk("sim_s_ready", bus.s_ready, 1);
            if (c >= 1) begin
                chk("sim_tx_valid", bus.tx_valid, 1);
                chk("sim_tx_data", bus.tx_data, 32'hC000_0000 + 32'(c - 1));
            end
            if (c >= 4) chk("sim_credits", credits, 4);
        end
        bus.s_valid = 1'b0;
        bus.cr_valid = 1'b0;

        // reset mid-operation discards everything
        rst = 1'b1;
        #1;
        chk("midrst_s_ready", bus.s_ready, 0);
        step();
        rst = 1'b0;
        #1;
        chk("midrst_credits", credits, 8);
        chk("midrst_idle", idle, 1);
        chk("midrst_tx_valid", bus.tx_valid, 0);
        chk("midrst_tx_data", bus.tx_data, 0);
        step();
        chk("midrst_no_launch", bus.tx_valid, 0);

        // overflow from idle
        bus.cr_valid = 1'b1;
        bus.cr_count = 4'd3;
        step();
        bus.cr_valid = 1'b0;
        chk("ovf_credits", credits, 8);
        chk("ovf_err", err_overflow, 1);
        step();
        step();
        chk("ovf_sticky", err_overflow, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("ovf_cleared", err_overflow, 0);

        // random soak against a FIFO model with one-cycle credit return
        ret_pending = 0;
        sdat = 32'h5000_0000;
        for (int c = 0; c < 1500; c++) begin
            bus.s_valid = ($urandom_range(0, 1) == 1);
            bus.s_data = sdat;
            bus.cr_valid = (ret_pending != 0);
            bus.cr_count = 4'd1;
            pop = (fifo_q.size() > 0) && ($urandom_range(0, 2) != 0);
            pre_sr = bus.s_ready;
            pre_tv = bus.tx_valid;
            pre_td = bus.tx_data;
            step();
            if (bus.s_valid && pre_sr) begin
                exp_q.push_back(sdat);
                sdat++;
            end
            if (pop) wd = fifo_q.pop_front();
            if (pre_tv) begin
                if (exp_q.size() == 0) begin
                    chk("soak_unexpected_write", 1, 0);
                end else begin
                    wd = exp_q.pop_front();
                    chk("soak_order", pre_td, wd);
                end
                fifo_q.push_back(pre_td);
                if (fifo_q.size() > DEPTH) chk("soak_fifo_overflow", fifo_q.size(), DEPTH);
            end
            ret_pending = pop ? 1 : 0;
            inv = int'(credits) + fifo_q.size() + ret_pending + int'(bus.tx_valid);
            chk("soak_credit_sum", inv, DEPTH);
        end
        bus.s_valid = 1'b0;
        bus.cr_valid = 1'b0;
        chk("soak_err", err_overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
